// File: rtl/sort6_pkg.sv
// Shared constants and types for the 6-entry descending sort sequencer.
package sort6_pkg;
    localparam int   DATA_W  = 4;
    localparam int   N_ENT   = 6;
    localparam logic MODE_ID = 1'b1;
    localparam logic MODE_GM = 1'b0;

    typedef enum logic [1:0] {IDLE, LOAD, SORT, OUT} state_e;
    typedef logic [N_ENT-1:0][DATA_W-1:0] keys_t;
endpackage

// File: rtl/sort6_net.sv
// Combinational 6-key descending sorting network (12 compare-exchange, depth 5).
module sort6_net
    import sort6_pkg::*;
(
    input  keys_t keys_i,
    output keys_t keys_o
);
    localparam int NCMP = 12;
    // Comparator pairs, layer by layer; the larger key always moves to LO.
    localparam int LO [NCMP] = '{0, 1, 2, 1, 3, 0, 2, 0, 2, 4, 1, 3};
    localparam int HI [NCMP] = '{5, 3, 4, 2, 4, 3, 5, 1, 3, 5, 2, 4};

    always_comb begin
        keys_t             v;
        logic [DATA_W-1:0] t;
        v = keys_i;
        t = '0;
        for (int i = 0; i < NCMP; i++) begin
            if (v[HI[i]] > v[LO[i]]) begin
                t        = v[LO[i]];
                v[LO[i]] = v[HI[i]];
                v[HI[i]] = t;
            end
        end
        keys_o = v;
    end
endmodule

// File: rtl/sort6_seq_ctrl.sv
// Collects 6 (ID, gm) entries, sorts on the latched key in one registered step,
// then streams the sorted keys largest-first over valid/ready.
module sort6_seq_ctrl
    import sort6_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_id,
    input  logic [DATA_W-1:0] in_gm,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);
    localparam logic [2:0] LAST = 3'(N_ENT - 1);

    state_e            state_q;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        rank_q, rank_d;
    logic              mode_q;
    keys_t             ent_id_q, ent_gm_q, res_q;
    keys_t             net_in, net_out;
    logic              in_ready_q, out_valid_q, out_last_q;
    logic [DATA_W-1:0] out_data_q;
    logic              in_hs;

    assign cnt_d  = cnt_q + 3'd1;
    assign rank_d = rank_q + 3'd1;
    assign in_hs  = in_valid && in_ready_q;
    assign net_in = (mode_q == MODE_ID) ? ent_id_q : ent_gm_q;

    sort6_net u_net (
        .keys_i (net_in),
        .keys_o (net_out)
    );

    // in_ready is a register so it stays low through reset and rises on the
    // first edge after release without ever looking at in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rank_q      <= '0;
            mode_q      <= MODE_GM;
            ent_id_q    <= '0;
            ent_gm_q    <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_hs) begin
                        ent_id_q[0] <= in_id;
                        ent_gm_q[0] <= in_gm;
                        mode_q      <= in_mode;
                        cnt_q       <= 3'd1;
                        state_q     <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_hs) begin
                        ent_id_q[cnt_q] <= in_id;
                        ent_gm_q[cnt_q] <= in_gm;
                        cnt_q           <= cnt_d;
                        if (cnt_q == LAST) begin
                            in_ready_q <= 1'b0;
                            state_q    <= SORT;
                        end
                    end
                end
                SORT: begin
                    res_q       <= net_out;
                    out_data_q  <= net_out[0];
                    out_valid_q <= 1'b1;
                    out_last_q  <= 1'b0;
                    rank_q      <= '0;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        if (rank_q == LAST) begin
                            out_valid_q <= 1'b0;
                            out_data_q  <= '0;
                            out_last_q  <= 1'b0;
                            in_ready_q  <= 1'b1;
                            cnt_q       <= '0;
                            rank_q      <= '0;
                            state_q     <= IDLE;
                        end else begin
                            rank_q     <= rank_d;
                            out_data_q <= res_q[rank_d];
                            out_last_q <= (rank_d == LAST);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_sort6_seq_ctrl.sv
// Bench for sort6_seq_ctrl: directed table rows, corner sequences and random frames.
module tb_sort6_seq_ctrl;
    import sort6_pkg::*;

    typedef logic [DATA_W-1:0] key_t;
    typedef struct {
        bit   mode;
        key_t id  [6];
        key_t gm  [6];
        bit   toggle;   // flip in_mode on entries 1..5
        int   gap_at;   // idle cycles inserted before this entry
        int   gap_len;
        bit   stall;    // out_ready pattern 1,0,0,1,...
        key_t exp [6];
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    key_t in_id = '0;
    key_t in_gm = '0;
    logic in_mode = 1'b0;
    logic out_valid;
    logic out_ready = 1'b0;
    key_t out_data;
    logic out_last;
    logic busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sort6_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_id     (in_id),
        .in_gm     (in_gm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: pick the largest remaining key of the selected field, six times.
    function automatic void ref_sort(input vec_t v, output key_t o [6]);
        key_t k [6];
        bit   used [6];
        int   best;
        for (int j = 0; j < 6; j++) begin
            k[j]    = v.mode ? v.id[j] : v.gm[j];
            used[j] = 1'b0;
        end
        for (int r = 0; r < 6; r++) begin
            best = -1;
            for (int j = 0; j < 6; j++)
                if (!used[j] && (best < 0 || k[j] > k[best])) best = j;
            o[r]       = k[best];
            used[best] = 1'b1;
        end
    endfunction

    // Called and returns at a negedge; w0 = wait cycles before entry 0 accepted.
    task automatic send(input vec_t v, output int w0);
        int w;
        w0 = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == v.gap_at && v.gap_len > 0) begin
                in_valid = 1'b0;
                for (int g = 0; g < v.gap_len; g++) begin
                    @(negedge clk);
                    chk("busy_in_gap", int'(busy), 1);
                end
            end
            in_valid = 1'b1;
            in_id    = v.id[i];
            in_gm    = v.gm[i];
            in_mode  = (i == 0) ? v.mode : (v.toggle ? ~v.mode : v.mode);
            w = 0;
            while (!in_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (w >= 50) chk("in_ready_timeout", 0, 1);
            if (i == 0) w0 = w;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input key_t exp [6], input bit stall, input string nm);
        int   r = 0;
        int   cyc = 0;
        int   t = 0;
        bit   have = 1'b0;
        bit   rdy;
        key_t held = '0;
        while (r < 6 && t < 200) begin
            rdy = stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            t++;
            if (out_valid) begin
                cyc++;
                chk("in_ready_during_out", int'(in_ready), 0);
                chk("busy_during_out", int'(busy), 1);
                if (have) chk({nm, "_stall_hold"}, int'(out_data), int'(held));
                out_ready = rdy;
                if (rdy) begin
                    chk({nm, "_key"}, int'(out_data), int'(exp[r]));
                    chk({nm, "_last"}, int'(out_last), (r == 5) ? 1 : 0);
                    r++;
                    have = 1'b0;
                end else begin
                    held = out_data;
                    have = 1'b1;
                end
            end else begin
                out_ready = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b0;
        if (r < 6) chk({nm, "_out_timeout"}, r, 6);
        chk({nm, "_idle_valid"}, int'(out_valid), 0);
        chk({nm, "_idle_busy"}, int'(busy), 0);
        chk({nm, "_idle_in_ready"}, int'(in_ready), 1);
    endtask

    // One full frame; the sort cycle and the 2-cycle latency are checked exactly.
    task automatic run_frame(input vec_t v, input string nm);
        int w0;
        send(v, w0);
        chk({nm, "_sort_valid"}, int'(out_valid), 0);
        chk({nm, "_sort_in_ready"}, int'(in_ready), 0);
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_lat_valid"}, int'(out_valid), 1);
        collect(v.exp, v.stall, nm);
    endtask

    vec_t tbl [4];
    vec_t v, va, vb;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w0;

        tbl[0].mode = 1'b1;
        tbl[0].id   = '{4'd3, 4'd9, 4'd1, 4'd7, 4'd0, 4'd5};
        tbl[0].gm   = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
        tbl[0].toggle = 1'b0; tbl[0].gap_at = -1; tbl[0].gap_len = 0; tbl[0].stall = 1'b0;
        tbl[0].exp  = '{4'd9, 4'd7, 4'd5, 4'd3, 4'd1, 4'd0};

        tbl[1].mode = 1'b0;
        tbl[1].id   = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10};
        tbl[1].gm   = '{4'd4, 4'd4, 4'd15, 4'd0, 4'd8, 4'd4};
        tbl[1].toggle = 1'b1; tbl[1].gap_at = -1; tbl[1].gap_len = 0; tbl[1].stall = 1'b0;
        tbl[1].exp  = '{4'd15, 4'd8, 4'd4, 4'd4, 4'd4, 4'd0};

        tbl[2].mode = 1'b1;
        tbl[2].id   = '{4'd2, 4'd11, 4'd6, 4'd6, 4'd14, 4'd1};
        tbl[2].gm   = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        tbl[2].toggle = 1'b0; tbl[2].gap_at = -1; tbl[2].gap_len = 0; tbl[2].stall = 1'b1;
        tbl[2].exp  = '{4'd14, 4'd11, 4'd6, 4'd6, 4'd2, 4'd1};

        tbl[3].mode = 1'b0;
        tbl[3].id   = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        tbl[3].gm   = '{4'd7, 4'd3, 4'd12, 4'd3, 4'd9, 4'd1};
        tbl[3].toggle = 1'b0; tbl[3].gap_at = 3; tbl[3].gap_len = 3; tbl[3].stall = 1'b0;
        tbl[3].exp  = '{4'd12, 4'd9, 4'd7, 4'd3, 4'd3, 4'd1};

        // Reset state
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rel_in_ready_pre", int'(in_ready), 0);
        @(posedge clk);
        @(negedge clk);
        chk("rel_in_ready_post", int'(in_ready), 1);

        for (int i = 0; i < 4; i++) run_frame(tbl[i], $sformatf("row%0d", i));

        // Same data as the gapped row, without the gap: identical result expected
        v = tbl[3];
        v.gap_at = -1;
        run_frame(v, "nogap");

        // Reset while rank 2 is on the output
        send(tbl[0], w0);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("midrst_rank2_key", int'(out_data), 5);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_data", int'(out_data), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_rel_in_ready", int'(in_ready), 1);
        v = tbl[0];
        v.id  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        v.exp = '{4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        run_frame(v, "postrst");

        // Back-to-back: next frame's entry 0 presented throughout the output phase
        va = tbl[0];
        vb = tbl[1];
        vb.toggle = 1'b0;
        send(va, w0);
        in_valid = 1'b1;
        in_id    = vb.id[0];
        in_gm    = vb.gm[0];
        in_mode  = vb.mode;
        @(posedge clk);
        @(negedge clk);
        collect(va.exp, 1'b0, "b2b_a");
        send(vb, w0);
        chk("b2b_entry0_wait", w0, 0);
        @(posedge clk);
        @(negedge clk);
        collect(vb.exp, 1'b0, "b2b_b");

        // Random frames against the reference model
        for (int f = 0; f < 20; f++) begin
            v.mode = 1'($urandom_range(0, 1));
            for (int j = 0; j < 6; j++) begin
                v.id[j] = 4'($urandom_range(0, 15));
                v.gm[j] = 4'($urandom_range(0, 15));
            end
            v.toggle  = 1'($urandom_range(0, 1));
            v.gap_at  = int'($urandom_range(1, 5));
            v.gap_len = int'($urandom_range(0, 2));
            v.stall   = 1'($urandom_range(0, 1));
            ref_sort(v, v.exp);
            run_frame(v, $sformatf("rnd%0d", f));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
